// File: rtl/noc_pkg.sv
// ============================================================================
// Module      : noc_pkg
// Description : Shared NoC flit field layout, flit types, sink error codes and
//               the packet sink state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package noc_pkg;

   localparam int COORD_W = 3;

   localparam logic [1:0] FLIT_INV  = 2'b00;
   localparam logic [1:0] FLIT_BODY = 2'b01;
   localparam logic [1:0] FLIT_TAIL = 2'b10;
   localparam logic [1:0] FLIT_HEAD = 2'b11;

   localparam int TYPE_HI  = 63;
   localparam int TYPE_LO  = 62;
   localparam int FID_HI   = 61;
   localparam int FID_LO   = 12;
   localparam int COORD_HI = 11;
   localparam int COORD_LO = 0;

   localparam int FID_W   = FID_HI - FID_LO + 1;
   localparam int CRD12_W = COORD_HI - COORD_LO + 1;
   localparam int PCNT_W  = 44;

   localparam logic [2:0] ERR_NONE   = 3'd0;
   localparam logic [2:0] ERR_ORPHAN = 3'd1;
   localparam logic [2:0] ERR_DEST   = 3'd2;
   localparam logic [2:0] ERR_HDR    = 3'd3;
   localparam logic [2:0] ERR_LEN    = 3'd4;
   localparam logic [2:0] ERR_TYPE   = 3'd5;
   localparam logic [2:0] ERR_ID     = 3'd6;
   localparam logic [2:0] ERR_SEQ    = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BODY = 2'd1,
      ST_DROP = 2'd2
   } sink_state_t;

   // When two errors hit the same flit, the lower non-zero code is reported.
   function automatic logic [2:0] err_pick(input logic [2:0] a, input logic [2:0] b);
      if (a == ERR_NONE)
         return b;
      else if (b == ERR_NONE)
         return a;
      else
         return (a < b) ? a : b;
   endfunction

endpackage

`default_nettype wire

// File: rtl/pkt_seq_table.sv
// ============================================================================
// Module      : pkt_seq_table
// Description : 64-entry per-source table of {valid, expected sequence}, with a
//               combinational read port and a single write port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module pkt_seq_table #(
   parameter int SEQ_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       i_rd_src,
   output logic             o_rd_valid,
   output logic [SEQ_W-1:0] o_rd_exp,
   input  logic             i_wr_en,
   input  logic [5:0]       i_wr_src,
   input  logic [SEQ_W-1:0] i_wr_exp
);

   localparam int c_depth = 64;

   logic [SEQ_W:0] r_tab [c_depth];

   for (genvar i = 0; i < c_depth; i++) begin : g_entry
      always_ff @(posedge clk or negedge reset) begin
         if (!reset)
            r_tab[i] <= '0;
         else if (i_wr_en && (i_wr_src == 6'(i)))
            r_tab[i] <= {1'b1, i_wr_exp};
      end
   end

   assign {o_rd_valid, o_rd_exp} = r_tab[i_rd_src];

endmodule

`default_nettype wire

// File: rtl/packet_sink.sv
// ============================================================================
// Module      : packet_sink
// Description : NoC ejection-port sink: reassembles fixed-length packets,
//               checks framing/destination/ID/sequence, publishes counters.
//               Optional backpressure via macro PACKET_SINK_STALL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module packet_sink
   import noc_pkg::*;
#(
   parameter int PKT_LEN = 4,
   parameter int SEQ_W   = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [COORD_W-1:0] dst_X,
   input  logic [COORD_W-1:0] dst_Y,
   input  logic [63:0]        Flit,
   input  logic               write_req,
   output logic               write_req_ack,
   output logic               pkt_done,
   output logic               err,
   output logic [2:0]         err_code,
   output logic [31:0]        pkt_count,
   output logic [15:0]        err_count,
   output logic [5:0]         last_src,
   output logic [FID_W-1:0]   last_flit_id
);

   localparam int c_bcnt_w = (PKT_LEN > 2) ? $clog2(PKT_LEN - 1) : 1;
   localparam logic [c_bcnt_w-1:0] c_bodies = c_bcnt_w'(PKT_LEN - 2);

   sink_state_t         r_state, w_state_nxt;
   logic [c_bcnt_w-1:0] r_body_cnt, w_bcnt_nxt;
   logic [CRD12_W-1:0]  r_hdr_coord;
   logic [FID_W-1:0]    r_hdr_fid;

   logic                r_ack;
   logic                r_pkt_done;
   logic                r_err;
   logic [2:0]          r_err_code;
   logic [31:0]         r_pkt_count;
   logic [15:0]         r_err_count;
   logic [5:0]          r_last_src;
   logic [FID_W-1:0]    r_last_fid;

   logic                w_xfer;
   logic [1:0]          w_type;
   logic [CRD12_W-1:0]  w_coord;
   logic [FID_W-1:0]    w_fid;
   logic [2:0]          w_head_err;
   logic                w_latch;
   logic                w_complete;
   logic [2:0]          w_err_code;
   logic                w_seq_valid;
   logic [SEQ_W-1:0]    w_seq_exp;
   logic [SEQ_W-1:0]    w_seq_cur;

   assign w_xfer  = write_req && r_ack;
   assign w_type  = Flit[TYPE_HI:TYPE_LO];
   assign w_coord = Flit[COORD_HI:COORD_LO];
   assign w_fid   = Flit[FID_HI:FID_LO];

   // Coordinates are {dest_Y, dest_X, src_Y, src_X}; the head ID must name the source.
   always_comb begin
      w_head_err = ERR_NONE;
      if (w_coord[11:6] != {dst_Y, dst_X})
         w_head_err = ERR_DEST;
      else if (w_fid[5:0] != w_coord[5:0])
         w_head_err = ERR_ID;
   end

   // Sequence number sits in the low bits of the packet counter above the ID.
   assign w_seq_cur = r_hdr_fid[6 +: SEQ_W];

   pkt_seq_table #(
      .SEQ_W (SEQ_W)
   ) u_seq_table (
      .clk        (clk),
      .reset      (reset),
      .i_rd_src   (r_hdr_coord[5:0]),
      .o_rd_valid (w_seq_valid),
      .o_rd_exp   (w_seq_exp),
      .i_wr_en    (w_complete),
      .i_wr_src   (r_hdr_coord[5:0]),
      .i_wr_exp   (w_seq_cur + SEQ_W'(1))
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_body_cnt  <= '0;
         r_hdr_coord <= '0;
         r_hdr_fid   <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_body_cnt <= w_bcnt_nxt;
         if (w_latch) begin
            r_hdr_coord <= w_coord;
            r_hdr_fid   <= w_fid;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_bcnt_nxt  = r_body_cnt;
      w_latch     = 1'b0;
      w_complete  = 1'b0;
      w_err_code  = ERR_NONE;
      if (w_xfer) begin
         case (w_type)
            FLIT_HEAD: begin
               w_latch     = 1'b1;
               w_bcnt_nxt  = '0;
               w_state_nxt = (w_head_err == ERR_NONE) ? ST_BODY : ST_DROP;
               // A head inside a packet truncates it before starting anew.
               w_err_code  = (r_state == ST_BODY) ? err_pick(ERR_LEN, w_head_err) : w_head_err;
            end
            FLIT_BODY: begin
               case (r_state)
                  ST_IDLE: w_err_code = ERR_ORPHAN;
                  ST_BODY: begin
                     if (w_coord != r_hdr_coord) begin
                        w_err_code  = ERR_HDR;
                        w_state_nxt = ST_DROP;
                     end else if (r_body_cnt == c_bodies) begin
                        w_err_code  = ERR_LEN;
                        w_state_nxt = ST_DROP;
                     end else begin
                        w_bcnt_nxt = r_body_cnt + c_bcnt_w'(1);
                     end
                  end
                  default: ;
               endcase
            end
            FLIT_TAIL: begin
               case (r_state)
                  ST_IDLE: w_err_code = ERR_ORPHAN;
                  ST_BODY: begin
                     w_state_nxt = ST_IDLE;
                     if (w_coord != r_hdr_coord)
                        w_err_code = ERR_HDR;
                     else if (r_body_cnt != c_bodies)
                        w_err_code = ERR_LEN;
                     else
                        w_complete = 1'b1;
                  end
                  default: w_state_nxt = ST_IDLE;
               endcase
            end
            default: begin
               w_err_code = ERR_TYPE;
               if (r_state == ST_BODY)
                  w_state_nxt = ST_DROP;
            end
         endcase
         if (w_complete && w_seq_valid && (w_seq_cur != w_seq_exp))
            w_err_code = ERR_SEQ;
      end
   end

`ifdef PACKET_SINK_STALL_EN
   logic [15:0] r_lfsr;
   logic        w_lfsr_fb;

   assign w_lfsr_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_lfsr <= 16'hACE1;
         r_ack  <= 1'b0;
      end else begin
         r_lfsr <= {w_lfsr_fb, r_lfsr[15:1]};
         r_ack  <= (r_lfsr[1:0] != 2'b00);
      end
   end
`else
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_ack <= 1'b0;
      else
         r_ack <= 1'b1;
   end
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pkt_done  <= 1'b0;
         r_err       <= 1'b0;
         r_err_code  <= ERR_NONE;
         r_pkt_count <= '0;
         r_err_count <= '0;
         r_last_src  <= '0;
         r_last_fid  <= '0;
      end else begin
         r_pkt_done <= w_complete;
         r_err      <= (w_err_code != ERR_NONE);
         if (w_err_code != ERR_NONE) begin
            r_err_code <= w_err_code;
            if (r_err_count != '1)
               r_err_count <= r_err_count + 16'd1;
         end
         if (w_complete) begin
            if (r_pkt_count != '1)
               r_pkt_count <= r_pkt_count + 32'd1;
            r_last_src <= r_hdr_coord[5:0];
            r_last_fid <= r_hdr_fid;
         end
      end
   end

   assign write_req_ack = r_ack;
   assign pkt_done      = r_pkt_done;
   assign err           = r_err;
   assign err_code      = r_err_code;
   assign pkt_count     = r_pkt_count;
   assign err_count     = r_err_count;
   assign last_src      = r_last_src;
   assign last_flit_id  = r_last_fid;

endmodule

`default_nettype wire

// File: tb/tb_packet_sink.sv
// ============================================================================
// Module      : tb_packet_sink
// Description : Directed self-checking bench for packet_sink.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_packet_sink;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [2:0]  dst_X = 3'd0;
   logic [2:0]  dst_Y = 3'd0;
   logic [63:0] Flit = 64'd0;
   logic        write_req = 1'b0;
   logic        write_req_ack;
   logic        pkt_done;
   logic        err;
   logic [2:0]  err_code;
   logic [31:0] pkt_count;
   logic [15:0] err_count;
   logic [5:0]  last_src;
   logic [49:0] last_flit_id;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc_total = 0;
   int cyc_low   = 0;

   packet_sink #(.PKT_LEN(4), .SEQ_W(8)) dut (
      .clk           (clk),
      .reset         (reset),
      .dst_X         (dst_X),
      .dst_Y         (dst_Y),
      .Flit          (Flit),
      .write_req     (write_req),
      .write_req_ack (write_req_ack),
      .pkt_done      (pkt_done),
      .err           (err),
      .err_code      (err_code),
      .pkt_count     (pkt_count),
      .err_count     (err_count),
      .last_src      (last_src),
      .last_flit_id  (last_flit_id)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] mk(input logic [1:0] t, input logic [2:0] dy, input logic [2:0] dx,
                                      input logic [2:0] sy, input logic [2:0] sx, input logic [43:0] cnt);
      if (t == 2'b11)
         return {t, cnt, sy, sx, dy, dx, sy, sx};
      return {t, 50'd0, dy, dx, sy, sx};
   endfunction

   // Called at a falling edge; returns at the falling edge after the transfer.
   task automatic send_flit(input logic [63:0] f, output logic d, output logic e);
      Flit = f;
      write_req = 1'b1;
      for (int k = 0; k < 200 && write_req_ack !== 1'b1; k++) begin
         cyc_total++;
         cyc_low++;
         @(negedge clk);
      end
      d = 1'b0;
      e = 1'b0;
      if (write_req_ack !== 1'b1) begin
         n_checks++;
         n_fail++;
         $display("FAIL ack_timeout: write_req_ack=%b, required 1", write_req_ack);
      end else begin
         cyc_total++;
         @(negedge clk);
         d = pkt_done;
         e = err;
      end
      write_req = 1'b0;
   endtask

   task automatic send_pkt(input logic [2:0] dy, input logic [2:0] dx, input logic [2:0] sy,
                           input logic [2:0] sx, input logic [43:0] cnt,
                           output logic [3:0] dm, output logic [3:0] em);
      send_flit(mk(2'b11, dy, dx, sy, sx, cnt), dm[0], em[0]);
      send_flit(mk(2'b01, dy, dx, sy, sx, 44'd0), dm[1], em[1]);
      send_flit(mk(2'b01, dy, dx, sy, sx, 44'd0), dm[2], em[2]);
      send_flit(mk(2'b10, dy, dx, sy, sx, 44'd0), dm[3], em[3]);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (write_req_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b, required 0", write_req_ack); end
      n_checks++;
      if ({pkt_done, err, err_code} !== 5'd0) begin n_fail++; $display("FAIL reset_pulses: got %b, required 0", {pkt_done, err, err_code}); end
      n_checks++;
      if ({pkt_count, err_count} !== 48'd0) begin n_fail++; $display("FAIL reset_counts: got %h, required 0", {pkt_count, err_count}); end
      n_checks++;
      if ({last_src, last_flit_id} !== 56'd0) begin n_fail++; $display("FAIL reset_last: got %h, required 0", {last_src, last_flit_id}); end
      reset = 1'b1;
      @(negedge clk);
      n_checks++;
      if (write_req_ack !== 1'b1) begin n_fail++; $display("FAIL ack_after_reset: got %b, required 1", write_req_ack); end
   endtask

   task automatic test_good_packet();
      logic [3:0] dm, em;
      do_reset();
      send_pkt(3'd0, 3'd0, 3'd2, 3'd1, 44'd0, dm, em);
      n_checks++;
      if (dm !== 4'b1000) begin n_fail++; $display("FAIL good_done: got %b, required 1000", dm); end
      n_checks++;
      if (em !== 4'b0000) begin n_fail++; $display("FAIL good_err: got %b, required 0000", em); end
      n_checks++;
      if (pkt_count !== 32'd1) begin n_fail++; $display("FAIL good_pkt_count: got %0d, required 1", pkt_count); end
      n_checks++;
      if (last_src !== 6'o21) begin n_fail++; $display("FAIL good_last_src: got %o, required 21", last_src); end
      n_checks++;
      if (last_flit_id !== 50'h11) begin n_fail++; $display("FAIL good_last_fid: got %h, required 11", last_flit_id); end
      n_checks++;
      if (err_count !== 16'd0) begin n_fail++; $display("FAIL good_err_count: got %0d, required 0", err_count); end
      repeat (3) @(negedge clk);
      n_checks++;
      if ({pkt_done, err, pkt_count} !== {2'b00, 32'd1}) begin n_fail++; $display("FAIL idle_stable: got %h, required 1", {pkt_done, err, pkt_count}); end
   endtask

   task automatic test_wrong_dest();
      logic [3:0] dm, em;
      do_reset();
      send_pkt(3'd3, 3'd3, 3'd2, 3'd1, 44'd0, dm, em);
      n_checks++;
      if (em !== 4'b0001) begin n_fail++; $display("FAIL dest_err: got %b, required 0001", em); end
      n_checks++;
      if (dm !== 4'b0000) begin n_fail++; $display("FAIL dest_done: got %b, required 0000", dm); end
      n_checks++;
      if (err_code !== 3'd2) begin n_fail++; $display("FAIL dest_code: got %0d, required 2", err_code); end
      n_checks++;
      if ({err_count, pkt_count} !== {16'd1, 32'd0}) begin n_fail++; $display("FAIL dest_counts: got %h, required 1_0", {err_count, pkt_count}); end
   endtask

   task automatic test_short_long();
      logic d, e;
      logic [3:0] dm, em;
      do_reset();
      send_flit(mk(2'b11, 3'd0, 3'd0, 3'd1, 3'd1, 44'd0), d, e);
      send_flit(mk(2'b01, 3'd0, 3'd0, 3'd1, 3'd1, 44'd0), d, e);
      send_flit(mk(2'b10, 3'd0, 3'd0, 3'd1, 3'd1, 44'd0), d, e);
      n_checks++;
      if ({d, e, err_code} !== {2'b01, 3'd4}) begin n_fail++; $display("FAIL short_tail: got %b, required 01100", {d, e, err_code}); end
      send_flit(mk(2'b11, 3'd0, 3'd0, 3'd1, 3'd1, 44'd0), d, e);
      send_flit(mk(2'b01, 3'd0, 3'd0, 3'd1, 3'd1, 44'd0), d, e);
      send_flit(mk(2'b01, 3'd0, 3'd0, 3'd1, 3'd1, 44'd0), d, e);
      n_checks++;
      if (e !== 1'b0) begin n_fail++; $display("FAIL long_body2: err got %b, required 0", e); end
      send_flit(mk(2'b01, 3'd0, 3'd0, 3'd1, 3'd1, 44'd0), d, e);
      n_checks++;
      if ({e, err_code} !== {1'b1, 3'd4}) begin n_fail++; $display("FAIL long_body3: got %b, required 1100", {e, err_code}); end
      send_flit(mk(2'b10, 3'd0, 3'd0, 3'd1, 3'd1, 44'd0), d, e);
      n_checks++;
      if ({d, e} !== 2'b00) begin n_fail++; $display("FAIL long_tail_drop: got %b, required 00", {d, e}); end
      n_checks++;
      if ({err_count, pkt_count} !== {16'd2, 32'd0}) begin n_fail++; $display("FAIL len_counts: got %h, required 2_0", {err_count, pkt_count}); end
      send_pkt(3'd0, 3'd0, 3'd1, 3'd1, 44'd0, dm, em);
      n_checks++;
      if ({dm, em} !== 8'b1000_0000) begin n_fail++; $display("FAIL len_recover: got %b, required 10000000", {dm, em}); end
   endtask

   task automatic test_orphan_type();
      logic d, e;
      logic [3:0] dm, em;
      do_reset();
      send_flit(mk(2'b10, 3'd0, 3'd0, 3'd1, 3'd1, 44'd0), d, e);
      n_checks++;
      if ({e, err_code} !== {1'b1, 3'd1}) begin n_fail++; $display("FAIL orphan_tail: got %b, required 1001", {e, err_code}); end
      send_flit(mk(2'b11, 3'd0, 3'd0, 3'd1, 3'd1, 44'd0), d, e);
      send_flit(mk(2'b01, 3'd0, 3'd0, 3'd1, 3'd1, 44'd0), d, e);
      send_flit(mk(2'b00, 3'd0, 3'd0, 3'd1, 3'd1, 44'd0), d, e);
      n_checks++;
      if ({e, err_code} !== {1'b1, 3'd5}) begin n_fail++; $display("FAIL type_in_body: got %b, required 1101", {e, err_code}); end
      send_flit(mk(2'b01, 3'd0, 3'd0, 3'd1, 3'd1, 44'd0), d, e);
      send_flit(mk(2'b10, 3'd0, 3'd0, 3'd1, 3'd1, 44'd0), d, e);
      n_checks++;
      if ({d, e, err_count} !== {2'b00, 16'd2}) begin n_fail++; $display("FAIL type_drop: got %h, required 2", {d, e, err_count}); end
      send_flit(mk(2'b11, 3'd0, 3'd0, 3'd1, 3'd1, 44'd0), d, e);
      send_flit(mk(2'b01, 3'd0, 3'd0, 3'd1, 3'd1, 44'd0), d, e);
      send_pkt(3'd0, 3'd0, 3'd1, 3'd1, 44'd0, dm, em);
      n_checks++;
      if ({em, dm} !== 8'b0001_1000) begin n_fail++; $display("FAIL head_in_body: got %b, required 00011000", {em, dm}); end
      n_checks++;
      if ({err_code, err_count, pkt_count} !== {3'd4, 16'd3, 32'd1}) begin n_fail++; $display("FAIL head_in_body_state: got %h, required 4_3_1", {err_code, err_count, pkt_count}); end
   endtask

   task automatic test_seq();
      logic [3:0] dm, em;
      do_reset();
      send_pkt(3'd0, 3'd0, 3'd2, 3'd1, 44'd0, dm, em);
      send_pkt(3'd0, 3'd0, 3'd2, 3'd1, 44'd1, dm, em);
      n_checks++;
      if ({dm, em} !== 8'b1000_0000) begin n_fail++; $display("FAIL seq_in_order: got %b, required 10000000", {dm, em}); end
      send_pkt(3'd0, 3'd0, 3'd2, 3'd1, 44'd3, dm, em);
      n_checks++;
      if ({dm, em} !== 8'b1000_1000) begin n_fail++; $display("FAIL seq_gap_pulses: got %b, required 10001000", {dm, em}); end
      n_checks++;
      if ({err_code, pkt_count} !== {3'd7, 32'd3}) begin n_fail++; $display("FAIL seq_gap_state: got %h, required 7_3", {err_code, pkt_count}); end
      send_pkt(3'd0, 3'd0, 3'd2, 3'd1, 44'd4, dm, em);
      n_checks++;
      if ({dm, em} !== 8'b1000_0000) begin n_fail++; $display("FAIL seq_resync: got %b, required 10000000", {dm, em}); end
      send_pkt(3'd0, 3'd0, 3'd4, 3'd3, 44'd255, dm, em);
      send_pkt(3'd0, 3'd0, 3'd4, 3'd3, 44'd0, dm, em);
      n_checks++;
      if ({dm, em} !== 8'b1000_0000) begin n_fail++; $display("FAIL seq_wrap: got %b, required 10000000", {dm, em}); end
      n_checks++;
      if ({pkt_count, err_count} !== {32'd6, 16'd1}) begin n_fail++; $display("FAIL seq_counts: got %h, required 6_1", {pkt_count, err_count}); end
      n_checks++;
      if ({last_src, last_flit_id} !== {6'o43, 50'h23}) begin n_fail++; $display("FAIL seq_last: got %h, required 43_23", {last_src, last_flit_id}); end
   endtask

   task automatic test_back_to_back();
      logic [3:0] dm, em;
      int c0;
      logic [3:0] all_d;
      do_reset();
      c0 = cyc_total;
      all_d = 4'd0;
      for (int i = 0; i < 5; i++) begin
         send_pkt(3'd0, 3'd0, 3'd5, 3'd6, 44'(i + 10), dm, em);
         all_d = all_d + {3'd0, dm[3]};
      end
      n_checks++;
      if ({all_d, pkt_count, err_count} !== {4'd5, 32'd5, 16'd0}) begin n_fail++; $display("FAIL b2b_counts: got %h, required 5_5_0", {all_d, pkt_count, err_count}); end
`ifndef PACKET_SINK_STALL_EN
      n_checks++;
      if (cyc_total - c0 !== 20) begin n_fail++; $display("FAIL b2b_rate: got %0d cycles, required 20", cyc_total - c0); end
`endif
   endtask

   task automatic test_reset_midpacket();
      logic d, e;
      logic [3:0] dm, em;
      do_reset();
      send_pkt(3'd0, 3'd0, 3'd1, 3'd1, 44'd0, dm, em);
      send_flit(mk(2'b11, 3'd0, 3'd0, 3'd1, 3'd1, 44'd1), d, e);
      #2 reset = 1'b0;
      #1;
      n_checks++;
      if ({write_req_ack, pkt_count, last_src, last_flit_id} !== 89'd0) begin n_fail++; $display("FAIL async_reset: got %h, required 0", {write_req_ack, pkt_count, last_src, last_flit_id}); end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      send_flit(mk(2'b10, 3'd0, 3'd0, 3'd1, 3'd1, 44'd0), d, e);
      n_checks++;
      if ({d, e, err_code, err_count} !== {2'b01, 3'd1, 16'd1}) begin n_fail++; $display("FAIL late_tail_orphan: got %h, required 1_1_1", {d, e, err_code, err_count}); end
   endtask

`ifdef PACKET_SINK_STALL_EN
   task automatic test_stall();
      logic [3:0] dm, em;
      int c0, l0, ct, lt;
      do_reset();
      c0 = cyc_total;
      l0 = cyc_low;
      for (int i = 0; i < 200; i++)
         send_pkt(3'd0, 3'd0, 3'd1, 3'd2, 44'(i), dm, em);
      ct = cyc_total - c0;
      lt = cyc_low - l0;
      n_checks++;
      if ({pkt_count, err_count} !== {32'd200, 16'd0}) begin n_fail++; $display("FAIL stall_counts: got %h, required 200_0", {pkt_count, err_count}); end
      n_checks++;
      if (lt * 100 < ct * 15 || lt * 100 > ct * 35) begin n_fail++; $display("FAIL stall_ratio: got %0d low of %0d cycles, required about 25 percent", lt, ct); end
   endtask
`endif

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time exceeded, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_good_packet();
      test_wrong_dest();
      test_short_long();
      test_orphan_type();
      test_seq();
      test_back_to_back();
      test_reset_midpacket();
`ifdef PACKET_SINK_STALL_EN
      test_stall();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
